lsu: RTL and testbench

- Load/store unit sitting directly upstream of the single-port word memory.
- Accepts one byte/half/word load or store request at a time from the core.
- Checks alignment and funct3.
- Drives the memory's strobe, address, write data and byte write mask.
- Applies the memory's 1-cycle registered read latency.
- Returns a shifted and sign- or zero-extended load result, or a store completion, as a one-cycle response pulse.

---
 rtl/lsu_pkg.sv | 26 ++
 rtl/lsu_align.sv | 64 ++++++
 rtl/lsu.sv | 113 +++++++++++
 tb/tb_lsu.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/lsu_pkg.sv
// Shared encodings for the load/store unit: RV32I width codes, FSM states and
// the latched request fields needed after the accept edge.
package lsu_pkg;

    localparam logic [2:0] LSU_B  = 3'b000;
    localparam logic [2:0] LSU_H  = 3'b001;
    localparam logic [2:0] LSU_W  = 3'b010;
    localparam logic [2:0] LSU_BU = 3'b100;
    localparam logic [2:0] LSU_HU = 3'b101;

    typedef enum logic [1:0] {
        LSU_IDLE   = 2'd0,
        LSU_ACCESS = 2'd1,
        LSU_WAIT   = 2'd2,
        LSU_RESP   = 2'd3
    } lsu_state_e;

    // Address and store data go straight into the memory-side registers,
    // so only what the load extract needs later is kept here.
    typedef struct packed {
        logic       we;
        logic [2:0] funct3;
        logic [1:0] off;
    } lsu_req_t;

endpackage

// File: rtl/lsu_align.sv
// Combinational lane logic: legality check, store lane placement and
// load byte/half extraction with sign or zero extension.
module lsu_align
    import lsu_pkg::*;
(
    input  logic        we,
    input  logic [2:0]  funct3,
    input  logic [1:0]  off,
    input  logic [31:0] wdata,
    input  logic [31:0] rdata,
    output logic        err,
    output logic [3:0]  wmask,
    output logic [31:0] wdata_lane,
    output logic [31:0] rdata_ext
);

    logic [7:0]  rd_byte;
    logic [15:0] rd_half;

    assign rd_byte = rdata[8*off +: 8];
    assign rd_half = rdata[16*off[1] +: 16];

    always_comb begin
        err        = 1'b0;
        wmask      = 4'b0000;
        wdata_lane = wdata;
        if (we) begin
            case (funct3)
                LSU_B: begin
                    wmask      = 4'b0001 << off;
                    wdata_lane = {4{wdata[7:0]}};
                end
                LSU_H: begin
                    err        = off[0];
                    wmask      = 4'b0011 << off;
                    wdata_lane = {2{wdata[15:0]}};
                end
                LSU_W: begin
                    err        = |off;
                    wmask      = 4'b1111;
                end
                default: err = 1'b1;
            endcase
        end else begin
            case (funct3)
                LSU_B, LSU_BU: err = 1'b0;
                LSU_H, LSU_HU: err = off[0];
                LSU_W:         err = |off;
                default:       err = 1'b1;
            endcase
        end
    end

    always_comb begin
        case (funct3)
            LSU_B:   rdata_ext = {{24{rd_byte[7]}}, rd_byte};
            LSU_BU:  rdata_ext = {24'd0, rd_byte};
            LSU_H:   rdata_ext = {{16{rd_half[15]}}, rd_half};
            LSU_HU:  rdata_ext = {16'd0, rd_half};
            default: rdata_ext = rdata;
        endcase
    end

endmodule

// File: rtl/lsu.sv
// Load/store unit in front of a single-port word memory with 1-cycle read
// latency: one request in flight, one-cycle response pulse.
module lsu
    import lsu_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [2:0]        req_funct3,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              resp_valid,
    output logic              resp_err,
    output logic [DATA_W-1:0] resp_rdata,
    output logic              mem_strb,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic [3:0]        mem_wmask,
    input  logic [DATA_W-1:0] mem_rdata
);

    lsu_state_e  state, state_nxt;
    lsu_req_t    req_q;
    logic        accept;
    logic        idle;
    logic [3:0]  mask_q;

    logic        al_we;
    logic [2:0]  al_funct3;
    logic [1:0]  al_off;
    logic        al_err;
    logic [3:0]  al_wmask;
    logic [31:0] al_wdata;
    logic [31:0] al_rdata;

    assign idle      = (state == LSU_IDLE);
    assign req_ready = idle;
    assign accept    = req_valid && req_ready;

    // In IDLE the aligner looks at the live request (error and store lanes);
    // afterwards it works from the latched fields for the load extract.
    assign al_we     = idle ? req_we            : req_q.we;
    assign al_funct3 = idle ? req_funct3        : req_q.funct3;
    assign al_off    = idle ? req_addr[1:0]     : req_q.off;

    lsu_align u_align (
        .we         (al_we),
        .funct3     (al_funct3),
        .off        (al_off),
        .wdata      (req_wdata),
        .rdata      (mem_rdata),
        .err        (al_err),
        .wmask      (al_wmask),
        .wdata_lane (al_wdata),
        .rdata_ext  (al_rdata)
    );

    // Gating with rstn keeps a store in ACCESS from committing on a reset edge.
    assign mem_wmask = mask_q & {4{rstn}};

    always_ff @(posedge clk) begin
        if (!rstn) state <= LSU_IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            LSU_IDLE:   if (accept) state_nxt = al_err ? LSU_RESP : LSU_ACCESS;
            LSU_ACCESS: state_nxt = req_q.we ? LSU_RESP : LSU_WAIT;
            LSU_WAIT:   state_nxt = LSU_RESP;
            LSU_RESP:   state_nxt = LSU_IDLE;
            default:    state_nxt = LSU_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            req_q      <= '0;
            resp_valid <= 1'b0;
            resp_err   <= 1'b0;
            resp_rdata <= '0;
            mem_strb   <= 1'b0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
            mask_q     <= 4'b0000;
        end else begin
            mem_strb   <= 1'b0;
            mask_q     <= 4'b0000;
            resp_valid <= (state_nxt == LSU_RESP);
            resp_err   <= 1'b0;
            resp_rdata <= '0;
            if (accept) begin
                req_q <= '{we: req_we, funct3: req_funct3, off: req_addr[1:0]};
                if (al_err) begin
                    resp_err <= 1'b1;
                end else begin
                    mem_strb  <= !req_we;
                    mask_q    <= req_we ? al_wmask : 4'b0000;
                    mem_addr  <= req_addr;
                    mem_wdata <= al_wdata;
                end
            end
            if (state == LSU_WAIT) resp_rdata <= al_rdata;
        end
    end

endmodule

// File: tb/tb_lsu.sv
// Directed bench for lsu with a small word memory model (registered read).
module tb_lsu;

    logic        clk = 1'b0;
    logic        rstn;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic        resp_err;
    logic [31:0] resp_rdata;
    logic        mem_strb;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_wmask;
    logic [31:0] mem_rdata;

    always #5 clk = ~clk;

    lsu #(.ADDR_W(32), .DATA_W(32)) dut (
        .clk        (clk),
        .rstn       (rstn),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_we     (req_we),
        .req_funct3 (req_funct3),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .resp_valid (resp_valid),
        .resp_err   (resp_err),
        .resp_rdata (resp_rdata),
        .mem_strb   (mem_strb),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_wmask  (mem_wmask),
        .mem_rdata  (mem_rdata)
    );

    logic [31:0] mem [0:63];

    initial begin
        for (int i = 0; i < 64; i++) mem[i] = 32'h0;
        mem[4] = 32'h8899AABB;
        mem[8] = 32'h11223344;
    end

    always @(posedge clk) begin
        if (mem_strb) mem_rdata <= mem[mem_addr[7:2]];
        for (int b = 0; b < 4; b++)
            if (mem_wmask[b]) mem[mem_addr[7:2]][8*b +: 8] <= mem_wdata[8*b +: 8];
    end

    // Monitor: activity counters and a log of every response pulse.
    int          strb_cnt = 0, wm_cnt = 0, acc_cnt = 0, ready_bad = 0, resp_n = 0;
    logic [3:0]  last_wm = '0;
    logic [31:0] last_wd = '0;
    logic [32:0] resp_log [0:63];

    always @(negedge clk) begin
        if (mem_strb) strb_cnt <= strb_cnt + 1;
        if (mem_wmask != 4'b0) begin
            wm_cnt  <= wm_cnt + 1;
            last_wm <= mem_wmask;
            last_wd <= mem_wdata;
        end
        if (req_valid && req_ready) acc_cnt <= acc_cnt + 1;
        if (resp_valid && req_ready) ready_bad <= ready_bad + 1;
        if (resp_valid) begin
            resp_log[resp_n[5:0]] <= {resp_err, resp_rdata};
            resp_n <= resp_n + 1;
        end
    end

    int n_chk = 0, n_err = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %08h exp %08h", tag, got, exp);
        end
    endtask

    // Issue one request, return response data, error, latency (0 if no
    // response pulse) and how many strobe / write-mask cycles the memory saw.
    task automatic do_req(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                          input logic [31:0] wd, input string tag,
                          output logic [31:0] rd, output logic er, output int lat,
                          output int ds, output int dw);
        int s0, w0;
        @(negedge clk);
        req_we = we; req_funct3 = f3; req_addr = addr; req_wdata = wd; req_valid = 1'b1;
        for (int i = 0; i < 20 && !req_ready; i++) @(negedge clk);
        chk({tag, "_ready"}, {31'd0, req_ready}, 32'd1);
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        req_we = 1'bx; req_funct3 = 3'bx; req_addr = 'x; req_wdata = 'x;
        s0 = strb_cnt; w0 = wm_cnt;
        lat = 0; rd = '0; er = 1'b0;
        for (int c = 1; c <= 10; c++) begin
            @(negedge clk);
            if (resp_valid) begin
                lat = c; rd = resp_rdata; er = resp_err;
                break;
            end
        end
        @(negedge clk);
        chk({tag, "_pulse1"}, {31'd0, resp_valid}, 32'd0);
        #1;
        ds = strb_cnt - s0;
        dw = wm_cnt - w0;
    endtask

    logic [31:0] rd;
    logic        er;
    int          lat, ds, dw, n0, a0;

    typedef struct {
        logic [2:0]  f3;
        logic [31:0] addr;
        logic [31:0] exp;
        string       tag;
    } load_vec_t;

    load_vec_t lv [5];
    load_vec_t qv [3];

    typedef struct {
        logic        we;
        logic [2:0]  f3;
        logic [31:0] addr;
        string       tag;
    } err_vec_t;

    err_vec_t ev [3];

    initial begin
        lv[0] = '{3'b000, 32'h13, 32'hFFFFFF88, "lb13"};
        lv[1] = '{3'b100, 32'h13, 32'h00000088, "lbu13"};
        lv[2] = '{3'b001, 32'h12, 32'hFFFF8899, "lh12"};
        lv[3] = '{3'b101, 32'h10, 32'h0000AABB, "lhu10"};
        lv[4] = '{3'b010, 32'h10, 32'h8899AABB, "lw10"};
        ev[0] = '{1'b0, 3'b010, 32'h12, "lw_mis"};
        ev[1] = '{1'b1, 3'b001, 32'h13, "sh_mis"};
        ev[2] = '{1'b0, 3'b011, 32'h10, "f3_011"};
        qv[0] = '{3'b010, 32'h10, 32'h88995ABB, "q0"};
        qv[1] = '{3'b100, 32'h10, 32'h000000BB, "q1"};
        qv[2] = '{3'b001, 32'h12, 32'hFFFF8899, "q2"};

        rstn = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_funct3 = '0;
        req_addr = '0; req_wdata = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_resp_valid", {31'd0, resp_valid}, 32'd0);
        chk("rst_resp_err",   {31'd0, resp_err},   32'd0);
        chk("rst_resp_rdata", resp_rdata, 32'd0);
        chk("rst_mem_strb",   {31'd0, mem_strb},   32'd0);
        chk("rst_mem_addr",   mem_addr,   32'd0);
        chk("rst_mem_wdata",  mem_wdata,  32'd0);
        chk("rst_mem_wmask",  {28'd0, mem_wmask},  32'd0);
        chk("rst_req_ready",  {31'd0, req_ready},  32'd1);
        rstn = 1'b1;

        for (int i = 0; i < 5; i++) begin
            do_req(1'b0, lv[i].f3, lv[i].addr, 32'h0, lv[i].tag, rd, er, lat, ds, dw);
            chk({lv[i].tag, "_data"}, rd, lv[i].exp);
            chk({lv[i].tag, "_err"},  {31'd0, er}, 32'd0);
            chk({lv[i].tag, "_lat"},  lat, 32'd3);
            chk({lv[i].tag, "_strb"}, ds, 32'd1);
        end

        do_req(1'b1, 3'b000, 32'h11, 32'h0000005A, "sb11", rd, er, lat, ds, dw);
        chk("sb11_lat",   lat, 32'd2);
        chk("sb11_err",   {31'd0, er}, 32'd0);
        chk("sb11_rdata", rd, 32'd0);
        chk("sb11_wmcyc", dw, 32'd1);
        chk("sb11_strb",  ds, 32'd0);
        chk("sb11_wmask", {28'd0, last_wm}, 32'h2);
        chk("sb11_wdata", last_wd, 32'h5A5A5A5A);
        do_req(1'b0, 3'b010, 32'h10, 32'h0, "lw_after_sb", rd, er, lat, ds, dw);
        chk("lw_after_sb_data", rd, 32'h88995ABB);

        for (int i = 0; i < 3; i++) begin
            do_req(ev[i].we, ev[i].f3, ev[i].addr, 32'hCAFEF00D, ev[i].tag, rd, er, lat, ds, dw);
            chk({ev[i].tag, "_err"},   {31'd0, er}, 32'd1);
            chk({ev[i].tag, "_lat"},   lat, 32'd1);
            chk({ev[i].tag, "_rdata"}, rd, 32'd0);
            chk({ev[i].tag, "_strb"},  ds, 32'd0);
            chk({ev[i].tag, "_wmask"}, dw, 32'd0);
        end

        // Reset asserted during the ACCESS cycle of a word store.
        @(negedge clk);
        req_we = 1'b1; req_funct3 = 3'b010; req_addr = 32'h20; req_wdata = 32'hDEADBEEF;
        req_valid = 1'b1;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        n0 = resp_n;
        @(negedge clk);
        chk("rstacc_wmask_pre", {28'd0, mem_wmask}, 32'hF);
        rstn = 1'b0;
        #1;
        chk("rstacc_wmask_gated", {28'd0, mem_wmask}, 32'h0);
        @(posedge clk);
        #1;
        rstn = 1'b1;
        repeat (5) @(negedge clk);
        #1;
        chk("rstacc_mem",   mem[8], 32'h11223344);
        chk("rstacc_noresp", resp_n - n0, 32'd0);
        chk("rstacc_ready", {31'd0, req_ready}, 32'd1);

        // Three loads with req_valid held high throughout.
        n0 = resp_n; a0 = acc_cnt;
        @(negedge clk);
        req_we = 1'b0; req_funct3 = qv[0].f3; req_addr = qv[0].addr; req_valid = 1'b1;
        for (int k = 0; k < 3; k++) begin
            for (int i = 0; i < 20 && !req_ready; i++) @(negedge clk);
            @(posedge clk);
            #1;
            if (k < 2) begin
                req_funct3 = qv[k+1].f3; req_addr = qv[k+1].addr;
            end else begin
                req_valid = 1'b0;
            end
        end
        for (int i = 0; i < 40 && (resp_n - n0) < 3; i++) @(negedge clk);
        repeat (2) @(negedge clk);
        #1;
        chk("q_accepts", acc_cnt - a0, 32'd3);
        chk("q_resps",   resp_n - n0,  32'd3);
        chk("q_ready_in_resp", ready_bad, 32'd0);
        for (int k = 0; k < 3; k++) begin
            chk({qv[k].tag, "_data"}, resp_log[(n0 + k) % 64][31:0], qv[k].exp);
            chk({qv[k].tag, "_err"},  {31'd0, resp_log[(n0 + k) % 64][32]}, 32'd0);
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
